demux2_4_reg: RTL and testbench

- Registered 1-to-2 demultiplexer: the distribution end of the 2:1 `mux2_4` selector path.
- Takes one WIDTH-bit valid/ready input stream and routes each word to output A (in_sel=0) or output B (in_sel=1).
- Each output has a one-entry output register, so a stalled sink on one side does not block traffic to the other side.
- Used where a single producer feeds two consumers, e.g. the register-file/ALU operand distribution path.

---
 rtl/demux2_4_if.sv | 42 ++++
 rtl/demux2_4_reg.sv | 133 +++++++++++++
 tb/tb_demux2_4_reg.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/demux2_4_if.sv
// -----------------------------------------------------------------------------
// demux2_4_if
// Bundle for the demux2_4_reg valid/ready paths: one input stream and two
// output streams (A and B).
//
//   master : the environment side (drives the input word and the sink readies)
//   slave  : the demultiplexer side (drives in_ready and both output streams)
//
// Signals
//   in_data  [WIDTH]  input word
//   in_sel            destination select, 0 = A, 1 = B
//   in_valid          input word present
//   in_ready          demux can accept the offered word this cycle
//   a_data   [WIDTH]  output A word,  a_valid / a_ready handshake
//   b_data   [WIDTH]  output B word,  b_valid / b_ready handshake
// -----------------------------------------------------------------------------
interface demux2_4_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] in_data;
   logic             in_sel;
   logic             in_valid;
   logic             in_ready;

   logic [WIDTH-1:0] a_data;
   logic             a_valid;
   logic             a_ready;

   logic [WIDTH-1:0] b_data;
   logic             b_valid;
   logic             b_ready;

   modport master (
      output in_data, in_sel, in_valid, a_ready, b_ready,
      input  in_ready, a_data, a_valid, b_data, b_valid
   );

   modport slave (
      input  in_data, in_sel, in_valid, a_ready, b_ready,
      output in_ready, a_data, a_valid, b_data, b_valid
   );
endinterface

// File: rtl/demux2_4_reg.sv
// -----------------------------------------------------------------------------
// demux2_4_reg
// Registered 1-to-2 demultiplexer. Each accepted input word is steered by
// in_sel into a one-entry output register for sink A (in_sel=0) or sink B
// (in_sel=1). The two output registers are independent, so a stalled sink on
// one side never blocks traffic headed to the other side. A word appears on
// its output exactly one clock after the input handshake, and each output
// sustains one word per clock (drain and reload in the same cycle).
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   bus       demux2_4_if.slave: in_* input stream, a_* / b_* output streams
//   count_a   [CNT_W] completed A handshakes (DEMUX_COUNT_EN builds only)
//   count_b   [CNT_W] completed B handshakes (DEMUX_COUNT_EN builds only)
//
// Build option
//   DEMUX_COUNT_EN : when defined, adds the wrapping per-output handshake
//                    counters and their ports. Otherwise they are absent and
//                    the datapath is unchanged.
// -----------------------------------------------------------------------------
module demux2_4_reg #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   demux2_4_if.slave        bus
`ifdef DEMUX_COUNT_EN
   ,
   output logic [CNT_W-1:0] count_a,
   output logic [CNT_W-1:0] count_b
`endif
);

   // Per-output occupancy; the state bit itself is the registered x_valid.
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;

   // Channel index 0 = A, 1 = B.
   logic [1:0]       ready_vec;
   logic [1:0]       space_vec;
   logic [1:0]       valid_vec;
   logic [1:0]       load_vec;
   logic [WIDTH-1:0] data_vec [2];
   logic             in_ready_int;
   logic             accept;

   assign ready_vec = {bus.b_ready, bus.a_ready};

   // in_ready looks only at the selected channel's space; in_valid is not
   // involved, so the source may use in_ready to decide whether to offer.
   assign in_ready_int = !reset && (bus.in_sel ? space_vec[1] : space_vec[0]);
   assign accept       = bus.in_valid && in_ready_int;

   // Only the selected channel sees a load; the other is left untouched.
   assign load_vec = {accept && bus.in_sel, accept && !bus.in_sel};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_ch
         state_e           state_q;
         state_e           state_d;
         logic [WIDTH-1:0] data_q;
         logic [WIDTH-1:0] data_d;
         logic             drain;

         assign drain = (state_q == ST_FULL) && ready_vec[gi];

         // A load wins over a drain: draining and reloading in one cycle
         // keeps the register FULL with the new word. Data is only written
         // on a load so it keeps its last value while EMPTY.
         always_comb begin
            state_d = state_q;
            data_d  = data_q;
            if (load_vec[gi]) begin
               state_d = ST_FULL;
               data_d  = bus.in_data;
            end else if (drain) begin
               state_d = ST_EMPTY;
            end
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               state_q <= ST_EMPTY;
               data_q  <= '0;
            end else begin
               state_q <= state_d;
               data_q  <= data_d;
            end
         end

         assign space_vec[gi] = (state_q == ST_EMPTY) || ready_vec[gi];
         assign valid_vec[gi] = (state_q == ST_FULL);
         assign data_vec[gi]  = data_q;

`ifdef DEMUX_COUNT_EN
         logic [CNT_W-1:0] cnt_q;
         logic [CNT_W-1:0] cnt_d;

         // Counts completed output handshakes; wraps naturally at 2^CNT_W.
         always_comb begin
            cnt_d = cnt_q;
            if (drain) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end
`endif
      end
   endgenerate

   assign bus.in_ready = in_ready_int;
   assign bus.a_valid  = valid_vec[0];
   assign bus.a_data   = data_vec[0];
   assign bus.b_valid  = valid_vec[1];
   assign bus.b_data   = data_vec[1];

`ifdef DEMUX_COUNT_EN
   assign count_a = g_ch[0].cnt_q;
   assign count_b = g_ch[1].cnt_q;
`endif

endmodule

// File: tb/tb_demux2_4_reg.sv
// -----------------------------------------------------------------------------
// tb_demux2_4_reg
// Self-checking bench for demux2_4_reg: directed scenarios followed by a
// randomized run, all compared against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_demux2_4_reg;
   localparam int WIDTH = 4;
   localparam int CNT_W = 8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   demux2_4_if #(.WIDTH(WIDTH)) bus ();

`ifdef DEMUX_COUNT_EN
   logic [CNT_W-1:0] count_a;
   logic [CNT_W-1:0] count_b;
`endif

   demux2_4_reg #(
      .WIDTH(WIDTH),
      .CNT_W(CNT_W)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .bus    (bus)
`ifdef DEMUX_COUNT_EN
      ,
      .count_a(count_a),
      .count_b(count_b)
`endif
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: each output is a queue holding at most one word.
   int q_a[$];
   int q_b[$];
   int last_a = 0;
   int last_b = 0;
   int cnt_a  = 0;
   int cnt_b  = 0;
   bit exp_rdy_last;
   logic seen_ready;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // One clock: drive inputs, check in_ready, advance model, check outputs.
   task automatic step(input bit r, input bit v, input bit s, input int d,
                       input bit ar, input bit br);
      bit exp_rdy;
      int dm;
      dm = d & ((1 << WIDTH) - 1);
      @(negedge clk);
      reset        = r;
      bus.in_valid = v;
      bus.in_sel   = s;
      bus.in_data  = WIDTH'(dm);
      bus.a_ready  = ar;
      bus.b_ready  = br;
      #1;
      exp_rdy = !r && (s ? (q_b.size() == 0 || br) : (q_a.size() == 0 || ar));
      exp_rdy_last = exp_rdy;
      seen_ready = bus.in_ready;
      check_eq("in_ready", int'(seen_ready), int'(exp_rdy));
      @(posedge clk);
      #1;
      if (r) begin
         q_a.delete();
         q_b.delete();
         last_a = 0;
         last_b = 0;
         cnt_a  = 0;
         cnt_b  = 0;
      end else begin
         if (q_a.size() != 0 && ar) begin
            void'(q_a.pop_front());
            cnt_a = (cnt_a + 1) % (1 << CNT_W);
         end
         if (q_b.size() != 0 && br) begin
            void'(q_b.pop_front());
            cnt_b = (cnt_b + 1) % (1 << CNT_W);
         end
         if (v && exp_rdy) begin
            if (s) begin
               q_b.push_back(dm);
               last_b = dm;
            end else begin
               q_a.push_back(dm);
               last_a = dm;
            end
         end
      end
      check_eq("a_valid", int'(bus.a_valid), int'(q_a.size() != 0));
      check_eq("a_data",  int'(bus.a_data),  last_a);
      check_eq("b_valid", int'(bus.b_valid), int'(q_b.size() != 0));
      check_eq("b_data",  int'(bus.b_data),  last_b);
`ifdef DEMUX_COUNT_EN
      check_eq("count_a", int'(count_a), cnt_a);
      check_eq("count_b", int'(count_b), cnt_b);
`endif
   endtask

   initial begin
      bit hold;
      bit hs;
      int hd;
      bit r, v, s;
      int d;

      reset        = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_sel   = 1'b0;
      bus.in_data  = '0;
      bus.a_ready  = 1'b0;
      bus.b_ready  = 1'b0;

      // Reset then route to A
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      check_eq("rst_a_valid", int'(bus.a_valid), 0);
      check_eq("rst_b_valid", int'(bus.b_valid), 0);
      step(0, 1, 0, 4'b0101, 1, 0);
      check_eq("route_a_valid", int'(bus.a_valid), 1);
      check_eq("route_a_data",  int'(bus.a_data), 4'b0101);
      check_eq("route_b_valid", int'(bus.b_valid), 0);

      // Select B
      step(0, 1, 1, 4'b0011, 1, 1);
      check_eq("selb_b_valid", int'(bus.b_valid), 1);
      check_eq("selb_b_data",  int'(bus.b_data), 4'b0011);
      check_eq("selb_a_hold",  int'(bus.a_data), 4'b0101);

      // Stall isolation
      step(0, 1, 0, 4'b1111, 0, 1);
      step(0, 1, 0, 4'b1110, 0, 1);
      check_eq("stall_in_ready", int'(seen_ready), 0);
      check_eq("stall_a_data",   int'(bus.a_data), 4'b1111);
      step(0, 1, 1, 4'b0001, 0, 1);
      check_eq("iso_in_ready", int'(seen_ready), 1);
      check_eq("iso_b_data",   int'(bus.b_data), 4'b0001);
      check_eq("iso_a_data",   int'(bus.a_data), 4'b1111);

      // Back-to-back to A
      for (int w = 1; w <= 4; w++) begin
         step(0, 1, 0, w, 1, 1);
         check_eq("b2b_in_ready", int'(seen_ready), 1);
         check_eq("b2b_a_data",   int'(bus.a_data), w);
         check_eq("b2b_a_valid",  int'(bus.a_valid), 1);
      end

      // Reset mid-operation with both outputs full and stalled
      step(0, 1, 1, 4'b1001, 0, 0);
      check_eq("mid_a_full", int'(bus.a_valid), 1);
      check_eq("mid_b_full", int'(bus.b_valid), 1);
      step(1, 1, 0, 4'b0101, 0, 0);
      check_eq("mid_rst_in_ready", int'(seen_ready), 0);
      check_eq("mid_rst_a_valid",  int'(bus.a_valid), 0);
      check_eq("mid_rst_b_valid",  int'(bus.b_valid), 0);
      check_eq("mid_rst_a_data",   int'(bus.a_data), 0);
      check_eq("mid_rst_b_data",   int'(bus.b_data), 0);

      // Counter wrap: 257 A handshakes, 3 B handshakes
      for (int i = 0; i < 257; i++) step(0, 1, 0, i, 1, 0);
      step(0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 1, i + 5, 0, 1);
      step(0, 0, 1, 0, 0, 1);
`ifdef DEMUX_COUNT_EN
      check_eq("wrap_count_a", int'(count_a), 1);
      check_eq("wrap_count_b", int'(count_b), 3);
`endif

      // Randomized traffic; the source holds an offered word until accepted
      hold = 1'b0;
      hs   = 1'b0;
      hd   = 0;
      for (int i = 0; i < 3000; i++) begin
         r = ($urandom_range(0, 99) == 0);
         if (hold) begin
            v = 1'b1;
            s = hs;
            d = hd;
         end else begin
            v = ($urandom_range(0, 3) != 0);
            s = 1'($urandom_range(0, 1));
            d = int'($urandom_range(0, 15));
         end
         step(r, v, s, d, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
         hold = v && !exp_rdy_last && !r;
         hs   = s;
         hd   = d;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
